// File: rtl/div_pkg.sv
// div_pkg: shared constants and state type
// for the sequential 16-bit divider.
package div_pkg;

  localparam int DIV_WIDTH = 16;

  localparam logic [15:0] DIV_ZERO_QUOT = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_16b_if.sv
// div_16b_if: request/result bundle between
// the divider and its requester.
interface div_16b_if
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, a, b,
    input  quot, rem, busy, done, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output quot, rem, busy, done, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// div_step: one combinational restoring step
// of the shift-subtract divider.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH:0]   r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] trial;
  logic             neg;

  // shift {R,Q} left, try subtracting the divisor
  always_comb begin
    shifted = {r_i, q_i[WIDTH-1]};
    trial   = shifted - {2'b00, d_i};
    neg     = trial[WIDTH+1];
    r_o     = neg ? shifted[WIDTH:0] : trial[WIDTH:0];
    q_o     = {q_i[WIDTH-2:0], ~neg};
  end

endmodule

// File: rtl/div_16b.sv
// div_16b: sequential unsigned divider,
// one quotient bit per cycle, registered outputs.
module div_16b
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  div_16b_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;

  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] q_d;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (d_q),
    .r_o (r_d),
    .q_o (q_d)
  );

  // control FSM with datapath and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.b == '0) begin
              quot_q  <= WIDTH'(DIV_ZERO_QUOT);
              rem_q   <= bus.a;
              dbz_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              q_q     <= bus.a;
              d_q     <= bus.b;
              r_q     <= '0;
              cnt_q   <= '0;
              dbz_q   <= 1'b0;
              state_q <= CALC;
            end
          end else begin
            // busy drops in the same cycle done does
            busy_q <= 1'b0;
          end
        end
        CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            quot_q  <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;

endmodule
